// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table constants for the 2-input gate response checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    HOLD    = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Expected y indexed by {a,b}
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_chk_settle.sv
// Observation register and stability counter: flags input changes and emits
// one settled pulse per stable interval of {a,b,y}.
module gate_chk_settle #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic y,
  output logic settled,
  output logic changed
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);

  logic [2:0]    obs_q;
  logic [CW-1:0] stab_cnt;

  assign changed = ({a, b, y} != obs_q);
  // Counter saturates one past the sample point, so the pulse fires once per interval
  assign settled = !changed && (stab_cnt == CW'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      obs_q    <= '0;
      stab_cnt <= '0;
    end else begin
      obs_q <= {a, b, y};
      if (changed)
        stab_cnt <= '0;
      else if (stab_cnt != CW'(SETTLE_CYCLES))
        stab_cnt <= stab_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/gate_tt_checker.sv
// Truth-table response checker for 2-input gates: samples settled vectors,
// tracks coverage and mismatches. Define GATE_CHK_TIMEOUT_EN for a coverage deadline.
module gate_tt_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE    = TT_OR,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned ERR_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       coverage,
  output logic [1:0]       first_err_vec,
  output logic             first_err_valid,
  output logic             timeout
);

  state_e           state_q, state_d;
  logic [ERR_W-1:0] err_d;
  logic [3:0]       cov_d;
  logic [1:0]       fev_d;
  logic             fval_d;
  logic             settled, changed;
  logic             do_sample, mismatch;
  logic [1:0]       vec;

  gate_chk_settle #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .y       (y),
    .settled (settled),
    .changed (changed)
  );

  assign vec      = {a, b};
  assign busy     = (state_q == MONITOR) || (state_q == HOLD);
  assign done     = (state_q == DONE);
  assign pass     = done && (coverage == 4'hF) && (err_cnt == '0);
  assign mismatch = (y != TRUTH_TABLE[vec]);

`ifdef GATE_CHK_TIMEOUT_EN
  logic [15:0] tcnt_q;
  logic        expire;
`endif

  always_comb begin
    state_d   = state_q;
    cov_d     = coverage;
    err_d     = err_cnt;
    fev_d     = first_err_vec;
    fval_d    = first_err_valid;
    do_sample = (state_q == MONITOR) && settled;
    if (do_sample) begin
      cov_d = coverage | (4'b0001 << vec);
      if (mismatch) begin
        if (err_cnt != '1)
          err_d = err_cnt + ERR_W'(1);
        if (!first_err_valid) begin
          fval_d = 1'b1;
          fev_d  = vec;
        end
      end
      state_d = HOLD;
    end else if (state_q == HOLD) begin
      if (coverage == 4'hF)
        state_d = DONE;
      else if (changed)
        state_d = MONITOR;
    end
`ifdef GATE_CHK_TIMEOUT_EN
    // Expiry is judged on post-sample coverage so a completing sample wins
    expire = busy && (tcnt_q == 16'(TIMEOUT_CYCLES - 1)) && (cov_d != 4'hF);
    if (expire)
      state_d = DONE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      coverage        <= '0;
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else if (start) begin
      state_q         <= MONITOR;
      coverage        <= '0;
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      state_q         <= state_d;
      coverage        <= cov_d;
      err_cnt         <= err_d;
      first_err_vec   <= fev_d;
      first_err_valid <= fval_d;
    end
  end

`ifdef GATE_CHK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst || start) begin
      tcnt_q  <= '0;
      timeout <= 1'b0;
    end else begin
      if (busy)
        tcnt_q <= tcnt_q + 16'd1;
      if (expire)
        timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: two instances (OR/settle 2, NOR/settle 4/2-bit errors)
// checked every cycle against a run-length based behavioural model.
module tb_gate_tt_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic a = 1'b0, b = 1'b0, y = 1'b0;

  logic       busy0, done0, pass0, fval0, tmo0;
  logic [7:0] err0;
  logic [3:0] cov0;
  logic [1:0] fev0;
  logic       busy1, done1, pass1, fval1, tmo1;
  logic [1:0] err1;
  logic [3:0] cov1;
  logic [1:0] fev1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_tt_checker #(.TRUTH_TABLE(4'b1110), .SETTLE_CYCLES(2), .ERR_W(8), .TIMEOUT_CYCLES(1024)) u0 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .y(y),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .coverage(cov0),
    .first_err_vec(fev0), .first_err_valid(fval0), .timeout(tmo0));

  gate_tt_checker #(.TRUTH_TABLE(4'b0001), .SETTLE_CYCLES(4), .ERR_W(2), .TIMEOUT_CYCLES(64)) u1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .y(y),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .coverage(cov1),
    .first_err_vec(fev1), .first_err_valid(fval1), .timeout(tmo1));

  // Reference model: a sample happens when the input triple has been present
  // at exactly SETTLE+1 consecutive edges while the checker is active.
  int         S[2]    = '{2, 4};
  int         EMAX[2] = '{255, 3};
  logic [3:0] TT[2]   = '{4'b1110, 4'b0001};
`ifdef GATE_CHK_TIMEOUT_EN
  int         TOV[2]  = '{1024, 64};
`endif

  logic [2:0] last_in;
  int  run;
  bit  armed = 0;
  int  m_cov[2], m_err[2], m_fev[2], m_tc[2];
  bit  m_fv[2], m_dn[2], m_tmo[2], m_act[2];

  task automatic model_step();
    logic [2:0] cur;
    logic [1:0] v;
    cur = {a, b, y};
    v   = {a, b};
    if (rst) begin
      armed   = 1;
      last_in = 3'b000;
      run     = 1;
      for (int i = 0; i < 2; i++) begin
        m_cov[i] = 0; m_err[i] = 0; m_fev[i] = 0; m_tc[i] = 0;
        m_fv[i] = 0; m_dn[i] = 0; m_tmo[i] = 0; m_act[i] = 0;
      end
    end else begin
      if (cur == last_in) begin
        if (run < 100000) run++;
      end else run = 1;
      last_in = cur;
      for (int i = 0; i < 2; i++) begin
        if (start) begin
          m_cov[i] = 0; m_err[i] = 0; m_fev[i] = 0; m_tc[i] = 0;
          m_fv[i] = 0; m_dn[i] = 0; m_tmo[i] = 0; m_act[i] = 1;
        end else if (m_act[i]) begin
          if (m_cov[i] == 15) begin
            m_dn[i] = 1; m_act[i] = 0;
          end else begin
            if (run == S[i] + 1) begin
              m_cov[i] = m_cov[i] | (1 << v);
              if (y != TT[i][v]) begin
                if (m_err[i] < EMAX[i]) m_err[i]++;
                if (!m_fv[i]) begin m_fv[i] = 1; m_fev[i] = int'(v); end
              end
            end
`ifdef GATE_CHK_TIMEOUT_EN
            m_tc[i]++;
            if (m_tc[i] == TOV[i] && m_cov[i] != 15) begin
              m_dn[i] = 1; m_tmo[i] = 1; m_act[i] = 0;
            end
`endif
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_inst(int i, logic bz, logic dn, logic ps, int er, logic [3:0] cv,
                          logic [1:0] fe, logic fv, logic tm);
    chk($sformatf("u%0d.busy", i), int'(bz), int'(m_act[i]));
    chk($sformatf("u%0d.done", i), int'(dn), int'(m_dn[i]));
    chk($sformatf("u%0d.pass", i), int'(ps), int'(m_dn[i] && m_cov[i] == 15 && m_err[i] == 0));
    chk($sformatf("u%0d.err_cnt", i), er, m_err[i]);
    chk($sformatf("u%0d.coverage", i), int'(cv), m_cov[i]);
    chk($sformatf("u%0d.first_err_vec", i), int'(fe), m_fev[i]);
    chk($sformatf("u%0d.first_err_valid", i), int'(fv), int'(m_fv[i]));
    chk($sformatf("u%0d.timeout", i), int'(tm), int'(m_tmo[i]));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk_inst(0, busy0, done0, pass0, int'(err0), cov0, fev0, fval0, tmo0);
      chk_inst(1, busy1, done1, pass1, int'(err1), cov1, fev1, fval1, tmo1);
    end
  end

  // Stimulus: all driving happens #1 after a rising edge.
  function automatic logic yfn(int mode, logic [1:0] v);
    case (mode)
      0:       return v != 2'b00;
      1:       return v == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  task automatic apply(logic [1:0] v, logic yy, int n);
    {a, b} = v;
    y = yy;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic seq4(int hold, int mode);
    for (int v = 0; v < 4; v++) apply(2'(v), yfn(mode, 2'(v)), hold);
  endtask

  initial begin
    logic [1:0] rv;
    logic       ry;
    int         rm;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset.done", int'(done0), 0);
    chk("reset.coverage", int'(cov0), 0);

    // Correct OR DUT
    apply(2'b11, 1'b1, 5);
    pulse_start();
    seq4(100, 0);
    apply(2'b11, 1'b1, 3);
    chk("or.done", int'(done0), 1);
    chk("or.pass", int'(pass0), 1);
    chk("or.err_cnt", int'(err0), 0);
    chk("or.coverage", int'(cov0), 15);

    // Stuck-at-0 output
    apply(2'b11, 1'b0, 5);
    pulse_start();
    seq4(100, 2);
    apply(2'b11, 1'b0, 3);
    chk("stuck.err_cnt", int'(err0), 3);
    chk("stuck.first_err_vec", int'(fev0), 1);
    chk("stuck.first_err_valid", int'(fval0), 1);
    chk("stuck.pass", int'(pass0), 0);

    // Glitch rejection on the settle-4 instance (NOR-correct y)
    apply(2'b10, 1'b0, 5);
    pulse_start();
    apply(2'b00, 1'b1, 8);
    apply(2'b11, 1'b0, 3);
    apply(2'b00, 1'b1, 8);
    chk("glitch.coverage", int'(cov1), 1);
    chk("glitch.err_cnt", int'(err1), 0);
    apply(2'b11, 1'b0, 5);
    chk("glitch.hold5.cov3", int'(cov1[3]), 1);
    apply(2'b11, 1'b0, 2);

    // Reset mid-run
    apply(2'b11, 1'b1, 5);
    pulse_start();
    apply(2'b00, 1'b0, 20);
    apply(2'b01, 1'b1, 20);
    pulse_rst();
    chk("rst.busy", int'(busy0), 0);
    chk("rst.coverage", int'(cov0), 0);
    chk("rst.first_err_valid", int'(fval1), 0);
    pulse_start();
    seq4(20, 0);
    apply(2'b11, 1'b1, 3);
    chk("rst.rerun.pass", int'(pass0), 1);

    // Saturation (u1 sees an inverted DUT) and restart from DONE
    apply(2'b11, 1'b1, 5);
    pulse_start();
    for (int k = 0; k < 2; k++)
      for (int v = 0; v < 3; v++) apply(2'(v), yfn(0, 2'(v)), 6);
    apply(2'b11, 1'b1, 6);
    apply(2'b11, 1'b1, 3);
    chk("sat.err_cnt", int'(err1), 3);
    chk("sat.done", int'(done1), 1);
    chk("sat.pass", int'(pass1), 0);
    chk("sat.u0.pass", int'(pass0), 1);
    pulse_start();
    chk("restart.err_cnt", int'(err1), 0);
    chk("restart.coverage", int'(cov1), 0);
    chk("restart.first_err_valid", int'(fval1), 0);
    chk("restart.busy", int'(busy1), 1);

`ifdef GATE_CHK_TIMEOUT_EN
    // Timeout on the 64-cycle instance with vector 11 never applied
    apply(2'b11, 1'b0, 5);
    pulse_start();
    apply(2'b00, 1'b1, 10);
    apply(2'b01, 1'b0, 10);
    apply(2'b10, 1'b0, 54);
    chk("tmo.done", int'(done1), 1);
    chk("tmo.timeout", int'(tmo1), 1);
    chk("tmo.pass", int'(pass1), 0);
    chk("tmo.coverage", int'(cov1), 7);
`endif

    // Randomized phase
    repeat (400) begin
      rv = 2'($urandom_range(0, 3));
      rm = $urandom_range(0, 9);
      ry = (rm < 5) ? yfn(0, rv) : (rm < 8) ? yfn(1, rv) : 1'($urandom_range(0, 1));
      apply(rv, ry, $urandom_range(1, 7));
      if ($urandom_range(0, 19) == 0) pulse_start();
      if ($urandom_range(0, 99) == 0) pulse_rst();
    end

    repeat (5) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
